axis_vis_serialiser: RTL and testbench
======================================

AXIS_VIS_SERIALISER -- requirements
Module: axis_vis_serialiser

Interface
REQ-001 SHALL have parameter ACCUM, default 32, meaning bit width of each real/imag visibility word (multiple of 8, minimum 8).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning byte order within a word (1 = MS byte first, 0 = LS byte first).
REQ-003 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: s_tvalid  in  1  input visibility valid.
REQ-006 SHALL have ports: s_tready  out  1  input accept.
REQ-007 SHALL have ports: s_tlast  in  1  last visibility of frame.
REQ-008 SHALL have ports: s_revis  in  ACCUM  real component.
REQ-009 SHALL have ports: s_imvis  in  ACCUM  imaginary component.
REQ-010 SHALL have ports: m_tvalid  out  1  output byte valid.
REQ-011 SHALL have ports: m_tready  in  1  output accept.
REQ-012 SHALL have ports: m_tlast  out  1  last byte of frame.
REQ-013 SHALL have ports: m_tdata  out  8  output byte.
REQ-014 SHALL have ports: busy_o  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL emit each accepted input as N = 2*ACCUM/8 bytes: all real bytes, then all imag bytes, each word ordered per MSB_FIRST.
REQ-016 SHALL implement states IDLE, SEND, CSUM; IDLE->SEND on s_tvalid&&s_tready; SEND->IDLE after byte N-1 handshake when no new word is accepted; SEND->CSUM only per REQ-027.
REQ-017 SHALL latch s_revis, s_imvis, s_tlast into a holding register on input handshake; m_tvalid asserts on the following cycle (latency 1) with byte 0.
REQ-018 SHALL drive s_tready high in IDLE, and in SEND only during the cycle in which byte N-1 is being handshaken (m_tvalid&&m_tready); low otherwise.
REQ-019 SHALL, on simultaneous byte N-1 handshake and input handshake, load the new word and present its byte 0 next cycle (zero-bubble back-to-back throughput).
REQ-020 SHALL advance the byte index only on m_tvalid&&m_tready; m_tdata and m_tlast SHALL stay stable while m_tvalid&&!m_tready.
REQ-021 SHALL never deassert m_tvalid without a handshake once asserted.
REQ-022 SHALL assert m_tlast only on byte N-1 of a word latched with s_tlast=1 (checksum disabled case).
REQ-023 SHALL treat a single-word frame (s_tlast=1 on first word) identically to REQ-022.
REQ-024 SHALL fail elaboration ($error) if ACCUM%8 != 0 or ACCUM < 8.

Reset
REQ-025 SHALL, on reset assertion (including mid-word), immediately force state=IDLE, byte index=0, m_tvalid=0, m_tlast=0, m_tdata=8'h00, s_tready=0, busy_o=0, checksum=0; the in-flight word is discarded.
REQ-026 SHALL assert s_tready=1 on the first clock edge after reset deasserts.

Configuration
REQ-027 With macro VIS_SERIALISER_CHECKSUM_EN defined: SHALL accumulate an 8-bit sum (mod 256) of every data byte handshaken in the frame; after byte N-1 of a tlast word, SHALL enter CSUM, emit the sum as one extra byte with m_tlast=1 (data byte N-1 then has m_tlast=0), hold s_tready low in CSUM, clear the sum on the checksum handshake, return to IDLE.
REQ-028 Without VIS_SERIALISER_CHECKSUM_EN: SHALL have no CSUM state and no checksum logic; framing per REQ-022.

Verification
REQ-029 ACCUM=32, MSB_FIRST=1, no macro, re=32'h01020304, im=32'h05060708, s_tlast=1, m_tready=1 -> bytes 01..08 on 8 consecutive cycles starting 1 cycle after accept, m_tlast only on 08.
REQ-030 Same stimulus with VIS_SERIALISER_CHECKSUM_EN -> 01..08 with m_tlast=0, then 9th byte 8'h24 with m_tlast=1.
REQ-031 Two back-to-back words, s_tvalid held high, m_tready=1 -> 16 bytes on 16 consecutive cycles, s_tready pulses exactly on cycle of byte 7.
REQ-032 m_tready toggling 1/0 every cycle -> m_tdata/m_tlast unchanged across stall cycles, byte sequence identical to REQ-029.
REQ-033 Reset asserted after byte 3 handshake -> m_tvalid=0 and busy_o=0 immediately; next word after release emits from its byte 0.
REQ-034 Checksum macro on, one word re=im=32'hFFFFFFFF, s_tlast=1 -> checksum byte 8'hF8 (wrap mod 256).

Source files
------------

// File: rtl/axis_vis_serialiser.sv
// axis_vis_serialiser: streams complex visibility words out as AXI-Stream bytes.
// Define VIS_SERIALISER_CHECKSUM_EN to append a mod-256 frame checksum byte.
module axis_vis_serialiser #(
  parameter int ACCUM     = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [ACCUM-1:0] s_revis,
  input  logic [ACCUM-1:0] s_imvis,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [7:0]       m_tdata,
  output logic             busy_o
);

  localparam int N  = 2 * ACCUM / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 2 * ACCUM;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if ((ACCUM % 8) != 0 || ACCUM < 8) begin : g_bad_accum
    $error("axis_vis_serialiser: ACCUM must be a multiple of 8 and >= 8");
  end

`ifdef VIS_SERIALISER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_e;
`else
  typedef enum logic {IDLE, SEND} state_e;
`endif

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] sr_q, sr_d;
  logic          last_q, last_d;
`ifdef VIS_SERIALISER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic [7:0]    cur_byte;
  logic [SW-1:0] load_vec;
  logic [SW-1:0] sr_shift;
  logic          at_last;
  logic          out_hs;
  logic          in_hs;

  // Word order (real then imag) and byte order both fall out of one shifter.
  assign load_vec = (MSB_FIRST != 0) ? {s_revis, s_imvis}
                                     : {s_imvis, s_revis};
  assign sr_shift = (MSB_FIRST != 0) ? {sr_q[SW-9:0], 8'h00}
                                     : {8'h00, sr_q[SW-1:8]};
  assign cur_byte = (MSB_FIRST != 0) ? sr_q[SW-1 -: 8] : sr_q[7:0];

  assign at_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign m_tvalid = (state_q != IDLE);
  assign busy_o   = (state_q != IDLE);
  assign out_hs   = m_tvalid && m_tready;

`ifdef VIS_SERIALISER_CHECKSUM_EN
  assign s_tready = !reset &&
                    ((state_q == IDLE) || (at_last && out_hs && !last_q));
`else
  assign s_tready = !reset && ((state_q == IDLE) || (at_last && out_hs));
`endif
  assign in_hs = s_tvalid && s_tready;

  always_comb begin
    m_tdata = 8'h00;
    m_tlast = 1'b0;
    if (state_q == SEND) begin
      m_tdata = cur_byte;
`ifdef VIS_SERIALISER_CHECKSUM_EN
      m_tlast = 1'b0;
`else
      m_tlast = at_last && last_q;
`endif
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    else if (state_q == CSUM) begin
      m_tdata = csum_q;
      m_tlast = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    last_d  = last_q;
`ifdef VIS_SERIALISER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (state_q == SEND && out_hs) begin
`ifdef VIS_SERIALISER_CHECKSUM_EN
      csum_d = csum_q + cur_byte;
`endif
      if (at_last) begin
        idx_d   = '0;
        state_d = IDLE;
`ifdef VIS_SERIALISER_CHECKSUM_EN
        if (last_q) state_d = CSUM;
`endif
      end else begin
        idx_d = idx_q + IW'(1);
        sr_d  = sr_shift;
      end
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    if (state_q == CSUM && out_hs) begin
      csum_d  = 8'h00;
      state_d = IDLE;
    end
`endif
    // A load overrides the end-of-word return to IDLE for zero-bubble reuse.
    if (in_hs) begin
      state_d = SEND;
      idx_d   = '0;
      sr_d    = load_vec;
      last_d  = s_tlast;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      last_q  <= 1'b0;
`ifdef VIS_SERIALISER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
`ifdef VIS_SERIALISER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_vis_serialiser.sv
// Directed bench for axis_vis_serialiser (ACCUM=32, MSB_FIRST=1).
// Checksum expectations switch on VIS_SERIALISER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_axis_vis_serialiser;

`ifdef VIS_SERIALISER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_revis = '0;
  logic [31:0] s_imvis = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [7:0]  m_tdata;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  axis_vis_serialiser #(.ACCUM(32), .MSB_FIRST(1)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_revis(s_revis), .s_imvis(s_imvis),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, busy_o, s_tready, m_tlast} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {m_tvalid, busy_o, s_tready, m_tlast});
    end
    checks++;
    if (m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_tdata: got %h expected 00", m_tdata);
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready: got %b expected 1", s_tready);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [0:7];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    s_revis = 32'h01020304;
    s_imvis = 32'h05060708;
    s_tlast = 1'b1;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got %b expected 1", s_tready);
    end
    step();
    s_tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp[i] ||
          m_tlast !== ((i == 7) && !CS)) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, m_tvalid, m_tdata, m_tlast, exp[i], (i == 7) && !CS);
      end
      step();
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h24 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL single_csum: got v=%b d=%h l=%b expected v=1 d=24 l=1",
               m_tvalid, m_tdata, m_tlast);
    end
    step();
`endif
    checks++;
    if (m_tvalid !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b expected 0 0",
               m_tvalid, busy_o);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [0:8];
    int k;
    bit tr;
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    k = 0;
    tr = 1'b0;
    s_revis = 32'h01020304;
    s_imvis = 32'h05060708;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    for (int c = 0; c < 40 && k < 8 + int'(CS); c++) begin
      m_tready = tr;
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp[k] ||
          m_tlast !== (CS ? (k == 8) : (k == 7))) begin
        errors++;
        $display("FAIL stall_c%0d_k%0d: got v=%b d=%h l=%b expected v=1 d=%h",
                 c, k, m_tvalid, m_tdata, m_tlast, exp[k]);
      end
      if (tr) k++;
      tr = !tr;
      step();
    end
    m_tready = 1'b1;
    checks++;
    if (k !== 8 + int'(CS) || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got bytes=%0d v=%b expected bytes=%0d v=0",
               k, m_tvalid, 8 + int'(CS));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [0:15];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    s_revis = 32'h01020304;
    s_imvis = 32'h05060708;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got %b expected 1", s_tready);
    end
    step();
    s_revis = 32'h11121314;
    s_imvis = 32'h15161718;
    s_tlast = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) s_tvalid = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp[c] ||
          m_tlast !== ((c == 15) && !CS)) begin
        errors++;
        $display("FAIL b2b_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 c, m_tvalid, m_tdata, m_tlast, exp[c], (c == 15) && !CS);
      end
      checks++;
      if (s_tready !== ((c == 7) || ((c == 15) && !CS))) begin
        errors++;
        $display("FAIL b2b_tready%0d: got %b expected %b",
                 c, s_tready, (c == 7) || ((c == 15) && !CS));
      end
      step();
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hC8 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_csum: got v=%b d=%h l=%b expected v=1 d=c8 l=1",
               m_tvalid, m_tdata, m_tlast);
    end
    step();
`endif
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got %b expected 0", m_tvalid);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] exp [0:7];
    exp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    s_revis = 32'hA1A2A3A4;
    s_imvis = 32'hB1B2B3B4;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, busy_o, s_tready, m_tlast} !== 4'b0000 ||
        m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset: got v=%b b=%b r=%b l=%b d=%h expected all 0",
               m_tvalid, busy_o, s_tready, m_tlast, m_tdata);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (s_tready !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got r=%b b=%b expected r=1 b=0",
               s_tready, busy_o);
    end
    s_revis = 32'hC1C2C3C4;
    s_imvis = 32'hD1D2D3D4;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp[i] ||
          m_tlast !== ((i == 7) && !CS)) begin
        errors++;
        $display("FAIL midreset_byte%0d: got v=%b d=%h l=%b expected v=1 d=%h",
                 i, m_tvalid, m_tdata, m_tlast, exp[i]);
      end
      step();
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    checks++;
    if (m_tdata !== 8'h54 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL midreset_csum: got d=%h l=%b expected d=54 l=1",
               m_tdata, m_tlast);
    end
    step();
`endif
  endtask

  task automatic test_all_ones();
    s_revis = 32'hFFFFFFFF;
    s_imvis = 32'hFFFFFFFF;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hFF ||
          m_tlast !== ((i == 7) && !CS)) begin
        errors++;
        $display("FAIL ones_byte%0d: got v=%b d=%h l=%b expected v=1 d=ff",
                 i, m_tvalid, m_tdata, m_tlast);
      end
      step();
    end
`ifdef VIS_SERIALISER_CHECKSUM_EN
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hF8 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL ones_csum: got v=%b d=%h l=%b expected v=1 d=f8 l=1",
               m_tvalid, m_tdata, m_tlast);
    end
    step();
`endif
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL ones_idle: got v=%b r=%b expected v=0 r=1",
               m_tvalid, s_tready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_midword();
    test_all_ones();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
